// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the fetch/data single-port RAM arbiter: FSM states, owner codes, grant helper.
package mem_port_arbiter_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE  = 2'd0,
      ARB_ISSUE = 2'd1,
      ARB_WAIT  = 2'd2,
      ARB_RESP  = 2'd3
   } arb_state_t;

   typedef enum logic {
      OWN_INST = 1'b0,
      OWN_DATA = 1'b1
   } owner_t;

   // Wide enough for RAM_LAT up to 15.
   localparam int CNT_W = 4;

   // On a tie with rotation enabled the port not granted last wins; otherwise data wins.
   function automatic owner_t pick_owner(input logic data_req, input logic inst_req,
                                         input owner_t last_own, input logic rr_en);
      if (data_req && inst_req && rr_en)
         return (last_own == OWN_DATA) ? OWN_INST : OWN_DATA;
      else if (data_req)
         return OWN_DATA;
      else
         return OWN_INST;
   endfunction

endpackage

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency single-port RAM between fetch and data ports, acking each access with a pulse.
// Define MEM_ARB_RR_EN for round-robin tie breaking; default build uses fixed DATA > INST priority.
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int ADDR_W  = 10,
   parameter int RAM_LAT = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              inst_ren,
   input  logic [31:0]       inst_addr,
   output logic [31:0]       inst_data,
   output logic              inst_ack,
   input  logic              mem_ren,
   input  logic              mem_wen,
   input  logic [31:0]       mem_addr,
   input  logic [31:0]       mem_dout,
   output logic [31:0]       mem_din,
   output logic              mem_ack,
   output logic              cpu_stall,
   output logic              ram_en,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [31:0]       ram_wdata,
   input  logic [31:0]       ram_rdata
);

   arb_state_t       state, state_nxt;
   owner_t           owner, grant;
   logic             we_q;
   logic [CNT_W-1:0] cnt;
   logic             data_req, inst_req, any_req;

   assign data_req = mem_ren | mem_wen;
   assign inst_req = inst_ren;
   assign any_req  = data_req | inst_req;

   assign cpu_stall = (inst_ren & ~inst_ack) | (data_req & ~mem_ack);

   logic unused_addr_bits;
   assign unused_addr_bits = ^{inst_addr[1:0], inst_addr[31:ADDR_W+2],
                               mem_addr[1:0], mem_addr[31:ADDR_W+2]};

`ifdef MEM_ARB_RR_EN
   owner_t last_own;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         last_own <= OWN_INST;
      else if (state == ARB_IDLE && any_req)
         last_own <= grant;
   end

   assign grant = pick_owner(data_req, inst_req, last_own, 1'b1);
`else
   assign grant = pick_owner(data_req, inst_req, OWN_INST, 1'b0);
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= ARB_IDLE;
      else
         state <= state_nxt;
   end

   // Reads always pass through WAIT so the capture edge lands on the cycle RAM data is valid.
   always_comb begin
      state_nxt = state;
      ram_en    = 1'b0;
      ram_we    = 1'b0;
      inst_ack  = 1'b0;
      mem_ack   = 1'b0;
      case (state)
         ARB_IDLE: begin
            if (any_req)
               state_nxt = ARB_ISSUE;
         end
         ARB_ISSUE: begin
            ram_en    = 1'b1;
            ram_we    = we_q;
            state_nxt = we_q ? ARB_RESP : ARB_WAIT;
         end
         ARB_WAIT: begin
            if (cnt == '0)
               state_nxt = ARB_RESP;
         end
         ARB_RESP: begin
            inst_ack  = (owner == OWN_INST);
            mem_ack   = (owner == OWN_DATA);
            state_nxt = ARB_IDLE;
         end
         default: state_nxt = ARB_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         owner     <= OWN_INST;
         we_q      <= 1'b0;
         cnt       <= '0;
         ram_addr  <= '0;
         ram_wdata <= '0;
         inst_data <= '0;
         mem_din   <= '0;
      end else begin
         case (state)
            ARB_IDLE: begin
               if (any_req) begin
                  owner <= grant;
                  if (grant == OWN_DATA) begin
                     we_q      <= mem_wen;
                     ram_addr  <= mem_addr[ADDR_W+1:2];
                     ram_wdata <= mem_dout;
                  end else begin
                     we_q      <= 1'b0;
                     ram_addr  <= inst_addr[ADDR_W+1:2];
                     ram_wdata <= '0;
                  end
               end
            end
            ARB_ISSUE: cnt <= CNT_W'(RAM_LAT - 1);
            ARB_WAIT: begin
               if (cnt == '0) begin
                  if (owner == OWN_INST)
                     inst_data <= ram_rdata;
                  else
                     mem_din <= ram_rdata;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: two instances (RAM_LAT 1 and 3) driven by directed and random
// transactions, checked against a transaction-level model of latency, ordering and memory contents.
module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        inst_ren [2];
   logic [31:0] inst_addr [2];
   logic [31:0] inst_data [2];
   logic        inst_ack [2];
   logic        mem_ren [2];
   logic        mem_wen [2];
   logic [31:0] mem_addr [2];
   logic [31:0] mem_dout [2];
   logic [31:0] mem_din [2];
   logic        mem_ack [2];
   logic        cpu_stall [2];
   logic        ram_en [2];
   logic        ram_we [2];
   logic [9:0]  ram_addr [2];
   logic [31:0] ram_wdata [2];
   logic [31:0] ram_rdata [2];

   int nvec = 0;
   int nerr = 0;

   logic [31:0] ref_mem [2][1024];
   logic [31:0] exp_inst [2];
   logic [31:0] exp_mem [2];

   always #5 clk = ~clk;

   mem_port_arbiter #(.ADDR_W(10), .RAM_LAT(1)) u_lat1 (
      .clk(clk), .rst_n(rst_n),
      .inst_ren(inst_ren[0]), .inst_addr(inst_addr[0]), .inst_data(inst_data[0]), .inst_ack(inst_ack[0]),
      .mem_ren(mem_ren[0]), .mem_wen(mem_wen[0]), .mem_addr(mem_addr[0]), .mem_dout(mem_dout[0]),
      .mem_din(mem_din[0]), .mem_ack(mem_ack[0]), .cpu_stall(cpu_stall[0]),
      .ram_en(ram_en[0]), .ram_we(ram_we[0]), .ram_addr(ram_addr[0]),
      .ram_wdata(ram_wdata[0]), .ram_rdata(ram_rdata[0])
   );

   mem_port_arbiter #(.ADDR_W(10), .RAM_LAT(3)) u_lat3 (
      .clk(clk), .rst_n(rst_n),
      .inst_ren(inst_ren[1]), .inst_addr(inst_addr[1]), .inst_data(inst_data[1]), .inst_ack(inst_ack[1]),
      .mem_ren(mem_ren[1]), .mem_wen(mem_wen[1]), .mem_addr(mem_addr[1]), .mem_dout(mem_dout[1]),
      .mem_din(mem_din[1]), .mem_ack(mem_ack[1]), .cpu_stall(cpu_stall[1]),
      .ram_en(ram_en[1]), .ram_we(ram_we[1]), .ram_addr(ram_addr[1]),
      .ram_wdata(ram_wdata[1]), .ram_rdata(ram_rdata[1])
   );

   function automatic logic [31:0] init_word(input int k, input int i);
      return (32'(i) * 32'h9E37_79B1) ^ ((k == 0) ? 32'h0000_5A5A : 32'hA5A5_0000);
   endfunction

   function automatic int lat_of(input int k);
      return (k == 0) ? 1 : 3;
   endfunction

   // Synchronous RAM: read data valid L cycles after the ram_en cycle, random filler otherwise.
   for (genvar g = 0; g < 2; g++) begin : g_ram
      localparam int L = (g == 0) ? 1 : 3;
      logic [31:0] mem [1024];
      logic [31:0] pipe [L];
      initial for (int i = 0; i < 1024; i++) mem[i] = init_word(g, i);
      always @(posedge clk) begin
         if (ram_en[g] && ram_we[g]) mem[ram_addr[g]] <= ram_wdata[g];
         pipe[0] <= (ram_en[g] && !ram_we[g]) ? mem[ram_addr[g]] : $urandom;
         for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
      end
      assign ram_rdata[g] = pipe[L-1];
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic set_req(input int k, input int kind, input logic v);
      case (kind)
         0:       inst_ren[k] = v;
         1:       mem_ren[k]  = v;
         default: mem_wen[k]  = v;
      endcase
   endtask

   // kind: 0 fetch, 1 data read, 2 data write. Called at posedge+1 with the DUT idle.
   task automatic run_txn(input int k, input int kind, input logic [31:0] addr,
                          input logic [31:0] wd, input bit drop_early);
      int lat;
      bit req_on;
      logic [9:0] wa;
      lat = (kind == 2) ? 2 : lat_of(k) + 2;
      wa  = addr[11:2];
      if (kind == 0) inst_addr[k] = addr;
      else begin mem_addr[k] = addr; mem_dout[k] = wd; end
      set_req(k, kind, 1'b1);
      req_on = 1'b1;
      for (int c = 0; c <= lat; c++) begin
         @(negedge clk);
         if (c == lat) begin
            if (kind == 0) exp_inst[k] = ref_mem[k][wa];
            else if (kind == 1) exp_mem[k] = ref_mem[k][wa];
            else ref_mem[k][wa] = wd;
         end
         chk("inst_ack", inst_ack[k], 32'(c == lat && kind == 0));
         chk("mem_ack", mem_ack[k], 32'(c == lat && kind != 0));
         chk("cpu_stall", cpu_stall[k], 32'(req_on && c != lat));
         chk("ram_en", ram_en[k], 32'(c == 1));
         if (c == 1) begin
            chk("ram_addr", ram_addr[k], 32'(wa));
            chk("ram_we", ram_we[k], 32'(kind == 2));
            if (kind == 2) chk("ram_wdata", ram_wdata[k], wd);
         end
         chk("inst_data", inst_data[k], exp_inst[k]);
         chk("mem_din", mem_din[k], exp_mem[k]);
         @(posedge clk); #1;
         if (drop_early && c == 0) begin
            set_req(k, kind, 1'b0);
            req_on = 1'b0;
         end
      end
      set_req(k, kind, 1'b0);
   endtask

   // Both ports held requesting; three grants, order decided by the arbitration policy.
   task automatic tie_test(input int k);
      int L, seen, nack;
      bit exp_ack, exp_data;
      logic [31:0] ia, ma;
      L  = lat_of(k);
      ia = 32'h0000_0104;
      ma = 32'h0000_0208;
      inst_addr[k] = ia; mem_addr[k] = ma;
      inst_ren[k] = 1'b1; mem_ren[k] = 1'b1;
      seen = 0; nack = 0;
      for (int c = 0; c < 60 && seen < 3; c++) begin
         @(negedge clk);
         exp_ack = (c == (L + 2) + seen * (L + 3));
`ifdef MEM_ARB_RR_EN
         exp_data = (seen % 2 == 0);
`else
         exp_data = 1'b1;
`endif
         if (exp_ack) begin
            if (exp_data) exp_mem[k] = ref_mem[k][ma[11:2]];
            else exp_inst[k] = ref_mem[k][ia[11:2]];
            seen++;
         end
         if (mem_ack[k] || inst_ack[k]) nack++;
         chk("tie_mem_ack", mem_ack[k], 32'(exp_ack && exp_data));
         chk("tie_inst_ack", inst_ack[k], 32'(exp_ack && !exp_data));
         chk("tie_inst_data", inst_data[k], exp_inst[k]);
         chk("tie_mem_din", mem_din[k], exp_mem[k]);
         @(posedge clk); #1;
      end
      chk("tie_ack_count", nack, 3);
      inst_ren[k] = 1'b0; mem_ren[k] = 1'b0;
   endtask

   task automatic idle_check(input int ncyc);
      for (int c = 0; c < ncyc; c++) begin
         @(negedge clk);
         for (int k = 0; k < 2; k++) begin
            chk("idle_ram_en", ram_en[k], 0);
            chk("idle_acks", {inst_ack[k], mem_ack[k]}, 0);
            chk("idle_stall", cpu_stall[k], 0);
            chk("idle_inst_data", inst_data[k], exp_inst[k]);
         end
      end
      @(posedge clk); #1;
   endtask

   initial begin
      rst_n = 1'b0;
      for (int k = 0; k < 2; k++) begin
         inst_ren[k] = 0; mem_ren[k] = 0; mem_wen[k] = 0;
         inst_addr[k] = 0; mem_addr[k] = 0; mem_dout[k] = 0;
         exp_inst[k] = 0; exp_mem[k] = 0;
         for (int i = 0; i < 1024; i++) ref_mem[k][i] = init_word(k, i);
      end
      repeat (3) @(posedge clk);
      #1;
      for (int k = 0; k < 2; k++) begin
         chk("rst_ram_en", ram_en[k], 0);
         chk("rst_ram_we", ram_we[k], 0);
         chk("rst_ram_addr", ram_addr[k], 0);
         chk("rst_ram_wdata", ram_wdata[k], 0);
         chk("rst_acks", {inst_ack[k], mem_ack[k]}, 0);
         chk("rst_inst_data", inst_data[k], 0);
         chk("rst_mem_din", mem_din[k], 0);
      end
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      idle_check(3);

      run_txn(0, 0, 32'h0000_0010, 0, 0);
      chk("fetch_ram4", inst_data[0], init_word(0, 4));
      run_txn(1, 2, 32'h0000_0040, 32'hDEAD_BEEF, 0);
      run_txn(1, 1, 32'h0000_0040, 0, 0);
      chk("rd_deadbeef", mem_din[1], 32'hDEAD_BEEF);
      run_txn(0, 1, 32'h0000_1003, 0, 0);
      run_txn(1, 0, 32'hFFFF_F3FC, 0, 1);
      run_txn(0, 2, 32'h8000_0044, 32'h1234_5678, 1);
      run_txn(0, 1, 32'h0000_0044, 0, 0);
      idle_check(2);

      for (int i = 0; i < 60; i++) begin
         int k, kind;
         logic [31:0] a;
         k    = $urandom_range(0, 1);
         kind = $urandom_range(0, 2);
         a    = $urandom;
         if ($urandom_range(0, 1) == 1) a[11:2] = 10'($urandom_range(0, 7));
         run_txn(k, kind, a, $urandom, $urandom_range(0, 3) == 0);
      end

      // Reset while instance 1 is waiting on RAM read data.
      run_txn(1, 0, 32'h0000_0020, 0, 0);
      inst_addr[1] = 32'h0000_0030;
      inst_ren[1]  = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #2;
      rst_n = 1'b0;
      #1;
      chk("arst_ram_en", ram_en[1], 0);
      chk("arst_inst_ack", inst_ack[1], 0);
      chk("arst_mem_ack", mem_ack[1], 0);
      chk("arst_inst_data", inst_data[1], 0);
      chk("arst_mem_din", mem_din[1], 0);
      inst_ren[1] = 1'b0;
      for (int k = 0; k < 2; k++) begin exp_inst[k] = 0; exp_mem[k] = 0; end
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      idle_check(6);

      run_txn(1, 0, 32'h0000_0030, 0, 0);
      tie_test(1);
      tie_test(0);
      idle_check(2);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
